seg7_capture: RTL and testbench
===============================

// Module: seg7_capture
// PURPOSE
//  Reverse of the display path: monitors the multiplexed, active-low anode and
//  segment lines of the 4-digit 7-seg display and recovers the digit codes shown.
//  Debounces each digit slot, decodes the segment pattern back to a 4-bit code
//  and reports per-digit updates plus a complete 16-bit frame.
//  Sits on the display pins (or on the display driver outputs in simulation) for
//  self-check and readback.
// PARAMETERS
//  STABLE_CYCLES  4  identical synced samples required before a digit is accepted (1..255)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous, active-low reset
//  an_n         in   4   anode enables, active-low, one-hot-low when a digit is driven
//  seg_n        in   7   segments, active-low, bit6=a .. bit0=g
//  err_clr      in   1   clears pattern_err (sync, one-cycle pulse)
//  digit_upd    out  1   one-cycle pulse: digit_idx/digit_val just captured
//  digit_idx    out  2   index of captured digit (an_n[i] low -> i)
//  digit_val    out  4   decoded code of captured digit
//  digits       out  16  last complete frame, {d3,d2,d1,d0}, 4 bits each
//  frame_valid  out  1   one-cycle pulse: digits updated with all four slots
//  pattern_err  out  1   sticky: a captured pattern was not in the decode table
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, sync flops to idle (an=1111, seg=1111111),
//   counter 0, seen mask 0000, state WAIT.
//  Input sync: an_n and seg_n pass through 2 flops; all logic uses the synced
//   sample S = {an, seg}. P = S from previous cycle.
//  Decode table (seg -> code): 0000001->0, 1001111->1, 0010010->2, 0000110->3,
//   1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9,
//   1111111 (blank)->F; any other pattern->E and sets pattern_err.
//  Single-digit condition: exactly one bit of an is 0.
//  FSM:
//   WAIT : S not single-digit. cnt=0. -> TRACK (cnt=1) when S single-digit.
//   TRACK: if S not single-digit -> WAIT, cnt=0. If S!=P -> stay, cnt=1.
//          If S==P: cnt++. When cnt reaches STABLE_CYCLES -> capture, go to HELD.
//          STABLE_CYCLES=1: capture on the first single-digit sample.
//   HELD : no further capture while S==P. S!=P -> TRACK (cnt=1) if single-digit,
//          else WAIT.
//  Capture (registered, outputs valid the cycle after the capturing edge):
//   digit_upd=1, digit_idx, digit_val=decode(seg), slot[idx]<=code, seen[idx]<=1.
//  Latency: inputs changed and then held -> digit_upd high STABLE_CYCLES+2 edges later.
//  Frame: if a capture makes seen==1111, the same edge loads digits from all
//   four slots (including the new code), pulses frame_valid and clears seen to 0000.
//   Re-capturing a slot already seen overwrites slot; no frame until all 4 are seen.
//  pattern_err: set on capture of an E code, held until err_clr. Set and clear in
//   the same cycle -> set wins.
//  Glitch rule: any change of S (anode or segment) before cnt reaches STABLE_CYCLES
//   restarts the count; no partial capture.
//  Reset mid-operation: everything returns to reset values immediately; a frame
//   in progress is discarded.
// TESTING
//  1 Hold an_n=1110, seg_n=0010010, STABLE_CYCLES=4 -> one digit_upd, idx=0, val=2,
//    exactly 6 edges after the inputs apply; no second pulse while held.
//  2 Scan digits 1,2,3,4 on idx 0..3 for 8 cycles each -> four digit_upd pulses,
//    then frame_valid with digits=16'h4321, seen cleared.
//  3 Toggle seg_n every 3 cycles on one anode (STABLE_CYCLES=4) -> no digit_upd.
//  4 Capture seg_n=1111111 -> val=F with no error; capture 0110000 -> val=E,
//    pattern_err=1 until err_clr; set and clear in the same cycle keeps it at 1.
//  5 Hold an_n=1100 or 1111 for 20 cycles -> FSM stays in WAIT, no pulses.
//  6 Assert rst_n=0 after 3 of 4 digits are captured -> outputs 0; a next full scan
//    needs all 4 digits again before frame_valid.

Source files
------------

// File: rtl/seg7_capture.sv
// Recovers digit codes from the multiplexed active-low anode/segment lines of a
// 4-digit 7-seg display: sync, per-slot debounce, decode, per-digit and frame reporting.
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an_n,
  input  logic [6:0]  seg_n,
  input  logic        err_clr,
  output logic        digit_upd,
  output logic [1:0]  digit_idx,
  output logic [3:0]  digit_val,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        pattern_err
);

  localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {StWait, StTrack, StHeld} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0]      an_s1_q, an_s2_q;
  logic [6:0]      seg_s1_q, seg_s2_q;
  logic [10:0]     s, p_q;
  logic            single;
  logic [1:0]      idx;
  logic [3:0]      code;
  logic            capture;
  logic [3:0][3:0] slot_q, slot_d;
  logic [3:0]      seen_q, seen_d;
  logic [15:0]     digits_q, digits_d;
  logic            digit_upd_q, digit_upd_d;
  logic [1:0]      digit_idx_q, digit_idx_d;
  logic [3:0]      digit_val_q, digit_val_d;
  logic            frame_valid_q, frame_valid_d;
  logic            pattern_err_q, pattern_err_d;

  assign s = {an_s2_q, seg_s2_q};

  always_comb begin
    single = 1'b1;
    idx    = 2'd0;
    case (an_s2_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: single = 1'b0;
    endcase
  end

  // Table is on the raw active-low pattern; anything unlisted decodes to E.
  always_comb begin
    case (seg_s2_q)
      7'b0000001: code = 4'h0;
      7'b1001111: code = 4'h1;
      7'b0010010: code = 4'h2;
      7'b0000110: code = 4'h3;
      7'b1001100: code = 4'h4;
      7'b0100100: code = 4'h5;
      7'b0100000: code = 4'h6;
      7'b0001111: code = 4'h7;
      7'b0000000: code = 4'h8;
      7'b0000100: code = 4'h9;
      7'b1111111: code = 4'hF;
      default:    code = 4'hE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      StWait: begin
        if (single) begin
          state_d = StTrack;
          cnt_d   = 8'd1;
        end else begin
          cnt_d = 8'd0;
        end
      end
      StTrack: begin
        if (!single) begin
          state_d = StWait;
          cnt_d   = 8'd0;
        end else if (s != p_q) begin
          cnt_d = 8'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHeld: begin
        if (s != p_q) begin
          state_d = single ? StTrack : StWait;
          cnt_d   = single ? 8'd1 : 8'd0;
        end
      end
      default: begin
        state_d = StWait;
        cnt_d   = 8'd0;
      end
    endcase
    // Covers both the normal count-out and the STABLE_CYCLES=1 first-sample case.
    if (state_d == StTrack && cnt_d == StableCnt) begin
      capture = 1'b1;
      state_d = StHeld;
      cnt_d   = 8'd0;
    end
  end

  always_comb begin
    slot_d        = slot_q;
    seen_d        = seen_q;
    digits_d      = digits_q;
    frame_valid_d = 1'b0;
    digit_upd_d   = capture;
    digit_idx_d   = digit_idx_q;
    digit_val_d   = digit_val_q;
    pattern_err_d = pattern_err_q;
    if (err_clr) pattern_err_d = 1'b0;
    if (capture) begin
      digit_idx_d   = idx;
      digit_val_d   = code;
      slot_d[idx]   = code;
      seen_d[idx]   = 1'b1;
      if (code == 4'hE) pattern_err_d = 1'b1;
      if (seen_d == 4'hF) begin
        digits_d      = slot_d;
        frame_valid_d = 1'b1;
        seen_d        = 4'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_q       <= 4'hF;
      an_s2_q       <= 4'hF;
      seg_s1_q      <= 7'h7F;
      seg_s2_q      <= 7'h7F;
      p_q           <= '1;
      state_q       <= StWait;
      cnt_q         <= 8'd0;
      slot_q        <= '0;
      seen_q        <= 4'h0;
      digits_q      <= 16'h0;
      digit_upd_q   <= 1'b0;
      digit_idx_q   <= 2'd0;
      digit_val_q   <= 4'h0;
      frame_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
    end else begin
      an_s1_q       <= an_n;
      an_s2_q       <= an_s1_q;
      seg_s1_q      <= seg_n;
      seg_s2_q      <= seg_s1_q;
      p_q           <= s;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      slot_q        <= slot_d;
      seen_q        <= seen_d;
      digits_q      <= digits_d;
      digit_upd_q   <= digit_upd_d;
      digit_idx_q   <= digit_idx_d;
      digit_val_q   <= digit_val_d;
      frame_valid_q <= frame_valid_d;
      pattern_err_q <= pattern_err_d;
    end
  end

  assign digit_upd   = digit_upd_q;
  assign digit_idx   = digit_idx_q;
  assign digit_val   = digit_val_q;
  assign digits      = digits_q;
  assign frame_valid = frame_valid_q;
  assign pattern_err = pattern_err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: expected captures/frames are queued when driven
// and checked as the DUT pulses digit_upd / frame_valid.
module tb_seg7_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        err_clr;
  logic        digit_upd;
  logic [1:0]  digit_idx;
  logic [3:0]  digit_val;
  logic [15:0] digits;
  logic        frame_valid;
  logic        pattern_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int upd_count = 0;
  int frame_count = 0;

  logic [5:0]  exp_q[$];
  logic [15:0] frame_q[$];

  seg7_capture #(.STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .err_clr    (err_clr),
    .digit_upd  (digit_upd),
    .digit_idx  (digit_idx),
    .digit_val  (digit_val),
    .digits     (digits),
    .frame_valid(frame_valid),
    .pattern_err(pattern_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge and score any pulses.
  task automatic tick();
    logic [5:0]  e;
    logic [15:0] f;
    @(posedge clk);
    #1;
    if (digit_upd === 1'b1) begin
      upd_count++;
      if (exp_q.size() == 0) begin
        check("upd_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("digit_idx", 32'(digit_idx), 32'(e[5:4]));
        check("digit_val", 32'(digit_val), 32'(e[3:0]));
      end
    end
    if (frame_valid === 1'b1) begin
      frame_count++;
      if (frame_q.size() == 0) begin
        check("frame_unexpected", 32'd1, 32'd0);
      end else begin
        f = frame_q.pop_front();
        check("frame_digits", 32'(digits), 32'(f));
      end
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply(input logic [3:0] a, input logic [6:0] sg);
    an_n  = a;
    seg_n = sg;
  endtask

  task automatic cap(input logic [1:0] i, input logic [6:0] sg, input logic [3:0] v);
    logic [3:0] a;
    a = ~(4'b0001 << i);
    exp_q.push_back({i, v});
    apply(a, sg);
    hold(8);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() + frame_q.size()) > 0 && n < 30) begin
      tick();
      n++;
    end
    check("queue_drain", 32'(exp_q.size() + frame_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_upd"},   32'(digit_upd),   32'd0);
    check({tag, "_idx"},   32'(digit_idx),   32'd0);
    check({tag, "_val"},   32'(digit_val),   32'd0);
    check({tag, "_digits"}, 32'(digits),     32'd0);
    check({tag, "_frame"}, 32'(frame_valid), 32'd0);
    check({tag, "_err"},   32'(pattern_err), 32'd0);
  endtask

  initial begin
    int n;
    int base;
    rst_n   = 1'b0;
    err_clr = 1'b0;
    apply(4'b1111, 7'b1111111);
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(3);

    // Single held digit: exact latency, then no repeat while held.
    exp_q.push_back({2'd0, 4'h2});
    apply(4'b1110, 7'b0010010);
    n = 0;
    while (digit_upd !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'd6);
    base = upd_count;
    hold(10);
    check("held_no_repeat", 32'(upd_count - base), 32'd0);

    // Scan 1,2,3,4 on slots 0..3 to form a frame.
    cap(2'd0, 7'b1001111, 4'h1);
    cap(2'd1, 7'b0010010, 4'h2);
    cap(2'd2, 7'b0000110, 4'h3);
    frame_q.push_back(16'h4321);
    cap(2'd3, 7'b1001100, 4'h4);
    drain();
    check("frame_count_scan", 32'(frame_count), 32'd1);
    check("digits_scan", 32'(digits), 32'h4321);

    // Segment toggling faster than the debounce window never captures.
    apply(4'b1111, 7'b1111111);
    hold(5);
    base = upd_count;
    for (int k = 0; k < 8; k++) begin
      apply(4'b1110, (k % 2 == 0) ? 7'b0000110 : 7'b1001111);
      hold(3);
    end
    apply(4'b1111, 7'b1111111);
    hold(6);
    check("toggle_no_upd", 32'(upd_count - base), 32'd0);

    // Blank decodes to F without error; an unknown pattern gives E and a sticky error.
    cap(2'd0, 7'b1111111, 4'hF);
    check("blank_no_err", 32'(pattern_err), 32'd0);
    cap(2'd1, 7'b0110000, 4'hE);
    check("bad_sets_err", 32'(pattern_err), 32'd1);
    hold(5);
    check("err_sticky", 32'(pattern_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", 32'(pattern_err), 32'd0);
    // err_clr coincides with the capturing edge of another bad pattern.
    exp_q.push_back({2'd2, 4'hE});
    apply(4'b1011, 7'b0110000);
    hold(5);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("set_wins_upd", 32'(digit_upd), 32'd1);
    check("set_wins_err", 32'(pattern_err), 32'd1);
    hold(2);
    drain();

    // Multiple or no anodes active: nothing captured.
    base = upd_count;
    apply(4'b1100, 7'b0000001);
    hold(20);
    apply(4'b1111, 7'b0000001);
    hold(20);
    check("multi_none_no_upd", 32'(upd_count - base), 32'd0);

    // Slots 0..2 were captured above; reset discards that partial frame.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    apply(4'b1111, 7'b1111111);
    tick();
    rst_n = 1'b1;
    hold(3);
    base = frame_count;
    cap(2'd3, 7'b0100100, 4'h5);
    check("no_frame_after_reset", 32'(frame_count - base), 32'd0);
    cap(2'd0, 7'b0100000, 4'h6);
    cap(2'd1, 7'b0001111, 4'h7);
    frame_q.push_back(16'h5876);
    cap(2'd2, 7'b0000000, 4'h8);
    drain();
    check("frame_count_rescan", 32'(frame_count - base), 32'd1);
    check("digits_rescan", 32'(digits), 32'h5876);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
